// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous single-port memory array between the instruction
//   fetch path (I) and the load/store path (D). One requester is granted per
//   cycle; read data (or store completion) is returned one cycle after grant.
//
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     ireq, iaddr                fetch request / byte address
//     igrant, ivalid, irdata     fetch grant (comb), response valid, data
//     stall                      ireq & ~igrant
//     dreq, dwe, daddr, dwdata   data request, store enable, address, data
//     dgrant, dvalid, drdata     data grant (comb), response valid, load data
//     mem_addr, mem_din, mem_we  memory array address / write data / enable
//     mem_dout                   memory array read data (one cycle latency)
//
//   Build option:
//     MEM_PORT_ARB_RR_EN  defined   -> round-robin between I and D on conflict
//                         undefined -> D priority, fetch forced after
//                                      STARVE_MAX consecutive denied cycles
module mem_port_arbiter #(
    parameter int DBITS      = 16,
    parameter int ABITS      = 12,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ireq,
    input  logic [DBITS-1:0] iaddr,
    output logic             igrant,
    output logic             ivalid,
    output logic [DBITS-1:0] irdata,
    output logic             stall,
    input  logic             dreq,
    input  logic             dwe,
    input  logic [DBITS-1:0] daddr,
    input  logic [DBITS-1:0] dwdata,
    output logic             dgrant,
    output logic             dvalid,
    output logic [DBITS-1:0] drdata,
    output logic [ABITS-1:0] mem_addr,
    output logic [DBITS-1:0] mem_din,
    output logic             mem_we,
    input  logic [DBITS-1:0] mem_dout
);

    typedef enum logic [1:0] {RSP_IDLE, RSP_I, RSP_D} rsp_t;

    rsp_t             rsp_q;
    logic             dwe_q;
    logic [ABITS-1:0] addr_q;
    logic             i_wins;

    // Byte-offset bit and bits above the word address are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{iaddr, daddr};

`ifdef MEM_PORT_ARB_RR_EN
    typedef enum logic {OWN_I, OWN_D} owner_t;
    owner_t last_owner;

    // On conflict, whoever did not own the memory last time goes next.
    assign i_wins = ~dreq | (last_owner == OWN_D);

    always_ff @(posedge clk) begin
        if (reset)
            last_owner <= OWN_D;
        else if (igrant)
            last_owner <= OWN_I;
        else if (dgrant)
            last_owner <= OWN_D;
    end
`else
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_cnt;

    assign i_wins = ~dreq | (starve_cnt == SW'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (reset)
            starve_cnt <= '0;
        else if (igrant)
            starve_cnt <= '0;
        else if (ireq && starve_cnt != SW'(STARVE_MAX))
            starve_cnt <= starve_cnt + 1'b1;
    end
`endif

    // Grants are suppressed while reset is asserted.
    assign igrant = ~reset & ireq & i_wins;
    assign dgrant = ~reset & dreq & ~igrant;
    assign stall  = ireq & ~igrant;

    // With no grant the array keeps seeing the last issued address.
    assign mem_addr = igrant ? iaddr[ABITS:1] :
                      dgrant ? daddr[ABITS:1] : addr_q;
    assign mem_din  = dwdata;
    assign mem_we   = dgrant & dwe;

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_q  <= RSP_IDLE;
            dwe_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            addr_q <= mem_addr;
            if (igrant)
                rsp_q <= RSP_I;
            else if (dgrant)
                rsp_q <= RSP_D;
            else
                rsp_q <= RSP_IDLE;
            if (dgrant)
                dwe_q <= dwe;
        end
    end

    // Valid is masked during reset so an in-flight response is dropped
    // in the very cycle reset is applied.
    assign ivalid = ~reset & (rsp_q == RSP_I);
    assign dvalid = ~reset & (rsp_q == RSP_D);
    assign irdata = ivalid ? mem_dout : '0;
    assign drdata = (dvalid & ~dwe_q) ? mem_dout : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with a write-first synchronous
//   memory model. Works for either build of MEM_PORT_ARB_RR_EN.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq, dreq, dwe;
    logic [15:0] iaddr, daddr, dwdata;
    logic        igrant, ivalid, stall, dgrant, dvalid, mem_we;
    logic [15:0] irdata, drdata, mem_din, mem_dout;
    logic [11:0] mem_addr;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [4096];

    always #5 clk = ~clk;

    mem_port_arbiter #(.DBITS(16), .ABITS(12), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .ireq(ireq), .iaddr(iaddr), .igrant(igrant), .ivalid(ivalid),
        .irdata(irdata), .stall(stall),
        .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
        .dgrant(dgrant), .dvalid(dvalid), .drdata(drdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .mem_dout(mem_dout)
    );

    // Write-first single-port synchronous array.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem_we ? mem_din : mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after posedge; checks happen mid-cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    function automatic logic exp_i_grant(input int k);
`ifdef MEM_PORT_ARB_RR_EN
        return (k % 2) == 0;
`else
        return (k % 5) == 4;
`endif
    endfunction

    initial begin
        logic prev_i, prev_d, ei;
        for (int i = 0; i < 4096; i++) mem[i] = 16'(i) ^ 16'hA5A5;
        mem_dout = '0;

        // Reset: grants and write enable held low despite requests
        reset = 1'b1; ireq = 1'b1; dreq = 1'b1; dwe = 1'b1;
        iaddr = 16'h0000; daddr = 16'h0000; dwdata = 16'h0000;
        next_cycle(); settle();
        check("rst_igrant", igrant, 0);
        check("rst_dgrant", dgrant, 0);
        check("rst_mem_we", mem_we, 0);
        next_cycle();
        reset = 1'b0; ireq = 1'b0; dreq = 1'b0; dwe = 1'b0;
        settle();
        check("rst_ivalid", ivalid, 0);
        check("rst_dvalid", dvalid, 0);
        check("rst_irdata", irdata, 0);
        check("rst_drdata", drdata, 0);
        check("rst_stall",  stall,  0);

        // T1: lone fetch
        next_cycle();
        ireq = 1'b1; iaddr = 16'h0200;
        settle();
        check("t1_igrant",   igrant,   1);
        check("t1_mem_addr", mem_addr, 12'h100);
        check("t1_stall",    stall,    0);
        next_cycle();
        ireq = 1'b0;
        settle();
        check("t1_ivalid", ivalid, 1);
        check("t1_irdata", irdata, 16'hA4A5);

        // T3: store then load of the same word (load address has high and low junk bits)
        next_cycle();
        dreq = 1'b1; dwe = 1'b1; daddr = 16'h0402; dwdata = 16'hBEEF;
        settle();
        check("t3_dgrant",   dgrant,   1);
        check("t3_mem_we",   mem_we,   1);
        check("t3_mem_addr", mem_addr, 12'h201);
        check("t3_mem_din",  mem_din,  16'hBEEF);
        next_cycle();
        dwe = 1'b0; daddr = 16'hE403; dwdata = 16'h0000;
        settle();
        check("t3_st_dvalid", dvalid,   1);
        check("t3_st_drdata", drdata,   0);
        check("t3_ld_addr",   mem_addr, 12'h201);
        check("t3_ld_we",     mem_we,   0);
        next_cycle();
        dreq = 1'b0;
        settle();
        check("t3_ld_dvalid", dvalid, 1);
        check("t3_ld_drdata", drdata, 16'hBEEF);

        // T6: five idle cycles
        next_cycle();
        for (int c = 0; c < 5; c++) begin
            next_cycle(); settle();
            check("t6_mem_we",   mem_we,   0);
            check("t6_ivalid",   ivalid,   0);
            check("t6_dvalid",   dvalid,   0);
            check("t6_stall",    stall,    0);
            check("t6_mem_addr", mem_addr, 12'h201);
        end

        // T4: fetch granted in N, reset in N+1
        next_cycle();
        ireq = 1'b1; iaddr = 16'h0010;
        settle();
        check("t4_igrant", igrant, 1);
        next_cycle();
        reset = 1'b1; ireq = 1'b0;
        settle();
        check("t4_ivalid_n1", ivalid, 0);
        next_cycle();
        reset = 1'b0;

        // T2/T5: both requesting continuously from the cycle after reset
        ireq = 1'b1; iaddr = 16'h0010; dreq = 1'b1; dwe = 1'b0; daddr = 16'h0020;
        prev_i = 1'b0; prev_d = 1'b0;
        for (int k = 0; k < 10; k++) begin
            settle();
            ei = exp_i_grant(k);
            check("t2_igrant", igrant, ei);
            check("t2_dgrant", dgrant, !ei);
            check("t2_stall",  stall,  !ei);
            check("t2_ivalid", ivalid, prev_i);
            check("t2_dvalid", dvalid, prev_d);
            if (prev_i) check("t2_irdata", irdata, 16'hA5AD);
            if (prev_d) check("t2_drdata", drdata, 16'hA5B5);
            prev_i = ei; prev_d = !ei;
            next_cycle();
        end
        ireq = 1'b0; dreq = 1'b0;
        settle();
        check("t2_last_ivalid", ivalid, prev_i);
        check("t2_last_dvalid", dvalid, prev_d);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
